epu_scheduler: RTL
==================

# epu_scheduler

Round-robin scheduler that shares one EPU (Ed25519 signature-verification unit: 512-bit signature, 256-bit key, 256-bit message, 1-bit result) among `N_REQ` requesters. It latches the granted requester's operands, issues one job to the EPU, waits for completion under a watchdog, and returns the verdict tagged with the requester index. It sits between the host-side request ports and the single EPU instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `TIMEOUT`, 65535: maximum EPU cycles per job before abort, ≥ 4.
- `clk`  in  1  single clock; all logic rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester job request.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_signature`  in  N_REQ*512  packed; requester i at [i*512 +: 512].
- `req_key`  in  N_REQ*256  packed, as above.
- `req_message`  in  N_REQ*256  packed, as above.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_id`  out  $clog2(N_REQ)  requester index of the completed job.
- `rsp_result`  out  1  EPU verdict (1 = signature valid); 0 on timeout.
- `rsp_timeout`  out  1  job aborted by watchdog.
- `busy`  out  1  high in every state except IDLE.
- `epu_signature`/`epu_key`/`epu_message`  out  512/256/256  latched operands to EPU.
- `epu_valid`  out  1  one-cycle job start to EPU.
- `epu_ready`  in  1  EPU idle / result-valid indicator.
- `epu_result`  in  1  EPU verdict; valid on the cycle `epu_ready` re-rises.

## Operation
- EPU contract: `epu_ready` high = idle. The EPU accepts on `epu_valid && epu_ready`. It drops `epu_ready` within 2 cycles and re-raises it together with a valid `epu_result`.
- States: IDLE, ISSUE, BUSY, RESP, DRAIN.
- IDLE:
  - If any `req_valid` and `epu_ready`, grant the first valid index at or after `rr_ptr`, wrapping.
  - `req_ready[grant]`=1 combinationally. On handshake, latch operands and `rsp_id`, set `rr_ptr`←grant+1 mod N_REQ, go ISSUE.
  - If `epu_ready`=0, no grant.
- ISSUE: `epu_valid`=1 for exactly one cycle; clear `seen_low` and the watchdog counter; go BUSY.
- BUSY:
  - Counter increments every cycle. `epu_ready`=0 sets `seen_low`.
  - `seen_low && epu_ready` → capture `epu_result`, go RESP.
  - Otherwise, when the counter reaches TIMEOUT−1: `rsp_timeout`←1, `rsp_result`←0, go RESP and mark drain.
  - Completion wins over a timeout in the same cycle.
- RESP: `rsp_valid`=1 for one cycle. Go DRAIN if the job timed out, else IDLE.
- DRAIN: wait for `epu_ready`=1 (an aborted job may still finish; its result is discarded), then go IDLE.
- Operand buses hold the last latched job; they change only on an IDLE handshake.
- `rr_ptr` advances only on a grant, so a requester that drops `req_valid` before being granted loses nothing.

## Timing
- Reset values (asynchronous): state=IDLE, `rr_ptr`=0, counter=0, `seen_low`=0. Outputs `req_ready`=0, `epu_valid`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_timeout`=0, `busy`=0, all `epu_*` operands=0.
- Handshake at cycle t → `epu_valid` at t+1 → `rsp_valid` one cycle after the `epu_ready` re-rise is sampled.
- Scheduler overhead is 3 cycles plus EPU latency. The next grant is possible on the cycle after RESP.
- Timeout: `rsp_valid` at ISSUE+TIMEOUT+1.
- Reset mid-job: everything returns to reset values immediately. The EPU is reset by the same `resetn`.
- `req_ready` is never high outside IDLE.

## Structure
- Package `epu_pkg`:
  - `SIG_W`=512, `KEY_W`=256, `MSG_W`=256.
  - State enum `epu_sched_state_t`.
  - `epu_job_t` struct (signature, key, message).
- Sub-module `rr_arbiter` (parameter N):
  - Inputs `req[N]`, `ptr`; outputs one-hot `gnt[N]` and `gnt_idx`; combinational.
  - FSM, watchdog and operand latch stay in `epu_scheduler`.

## Test plan
- Single job: N_REQ=4, requester 2 valid, EPU model returns result=1 after 20 cycles → `epu_valid` one cycle after the handshake; `rsp_valid` with `rsp_id`=2, `rsp_result`=1, `rsp_timeout`=0; operands match requester 2.
- Round robin: all 4 requesters continuously valid → grant order 0,1,2,3,0,…; no requester is granted twice before every other one is served.
- Timeout: TIMEOUT=16, EPU never re-raises `epu_ready` until cycle 40 → `rsp_valid` at ISSUE+17 with `rsp_timeout`=1, `rsp_result`=0; no grant until `epu_ready` returns, then the late result is ignored.
- EPU not ready: `epu_ready`=0 while in IDLE with `req_valid`=4'b0001 → `req_ready` stays 0 until `epu_ready`=1.
- Completion and timeout in the same cycle: completion at exactly TIMEOUT−1 → `rsp_timeout`=0, `rsp_result` = EPU value, next state IDLE.
- Reset mid-job: deassert `resetn` during BUSY → all outputs at reset values within the same cycle; after release, requester 0 is granted first.

Source files
------------

// File: rtl/epu_pkg.sv
`default_nettype none
// ============================================================================
// epu_pkg : operand widths, scheduler state encoding and job record
// Revision : 1.0
// ============================================================================
package epu_pkg;

  localparam int SIG_W = 512;
  localparam int KEY_W = 256;
  localparam int MSG_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } epu_sched_state_t;

  typedef struct packed {
    logic [SIG_W-1:0] signature;
    logic [KEY_W-1:0] key;
    logic [MSG_W-1:0] message;
  } epu_job_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick of the first request at or
//              after ptr, wrapping; one-hot grant plus its index
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;

  logic [PW-1:0] w_pos;
  logic          w_found;

  // One extra bit so ptr+i can exceed N-1 before the modulo fold
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = {1'b0, ptr} + PW'(i);
      if (w_pos >= PW'(N)) w_pos = w_pos - PW'(N);
      if (!w_found && req[w_pos[IW-1:0]]) begin
        w_found              = 1'b1;
        gnt[w_pos[IW-1:0]]   = 1'b1;
        gnt_idx              = w_pos[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/epu_scheduler.sv
`default_nettype none
// ============================================================================
// epu_scheduler : round-robin sharing of one Ed25519 verify unit among
//                 N_REQ requesters, with watchdog abort and drain
// Revision      : 1.0
// ============================================================================
module epu_scheduler
  import epu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*SIG_W-1:0]     req_signature,
  input  logic [N_REQ*KEY_W-1:0]     req_key,
  input  logic [N_REQ*MSG_W-1:0]     req_message,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       rsp_result,
  output logic                       rsp_timeout,
  output logic                       busy,
  output logic [SIG_W-1:0]           epu_signature,
  output logic [KEY_W-1:0]           epu_key,
  output logic [MSG_W-1:0]           epu_message,
  output logic                       epu_valid,
  input  logic                       epu_ready,
  input  logic                       epu_result
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  epu_sched_state_t r_state, w_next;
  logic [IW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_seen_low;
  epu_job_t         r_job;
  logic [IW-1:0]    r_rsp_id;
  logic             r_rsp_result;
  logic             r_rsp_timeout;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_hs;
  logic             w_done;
  logic             w_wd;
  epu_job_t         w_sel_job;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_job.signature = req_signature[32'(w_gnt_idx)*SIG_W +: SIG_W];
    w_sel_job.key       = req_key[32'(w_gnt_idx)*KEY_W +: KEY_W];
    w_sel_job.message   = req_message[32'(w_gnt_idx)*MSG_W +: MSG_W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_hs      = 1'b0;
    w_done    = 1'b0;
    w_wd      = 1'b0;
    req_ready = '0;
    epu_valid = 1'b0;
    rsp_valid = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        // resetn gate keeps req_ready at zero while reset is held
        if (resetn && epu_ready && (|req_valid)) begin
          req_ready = w_gnt;
          w_hs      = 1'b1;
          w_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        epu_valid = 1'b1;
        w_next    = ST_BUSY;
      end
      ST_BUSY: begin
        // A completion on the watchdog's last cycle still delivers its verdict
        if (r_seen_low && epu_ready) begin
          w_done = 1'b1;
          w_next = ST_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_wd   = 1'b1;
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        w_next    = r_rsp_timeout ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (epu_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_seen_low    <= 1'b0;
      r_job         <= '0;
      r_rsp_id      <= '0;
      r_rsp_result  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_hs) begin
        r_job    <= w_sel_job;
        r_rsp_id <= w_gnt_idx;
        r_ptr    <= (w_gnt_idx == IW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt      <= '0;
        r_seen_low <= 1'b0;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (!epu_ready) r_seen_low <= 1'b1;
      end
      if (w_done) begin
        r_rsp_result  <= epu_result;
        r_rsp_timeout <= 1'b0;
      end else if (w_wd) begin
        r_rsp_result  <= 1'b0;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign rsp_id        = r_rsp_id;
  assign rsp_result    = r_rsp_result;
  assign rsp_timeout   = r_rsp_timeout;
  assign epu_signature = r_job.signature;
  assign epu_key       = r_job.key;
  assign epu_message   = r_job.message;

endmodule
`default_nettype wire
